// File: rtl/lipsi_disp_pkg.sv
// Shared types and constants for the Lipsi BCD display block.
// Holds the conversion FSM states, segment patterns (active-low, bit 6 = a,
// bit 0 = g), anode enables (active-low) and the add-3 digit adjust helper.
package lipsi_disp_pkg;

  // Conversion FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Number of BCD digits produced and width of the iteration counter.
  // DATA_W is at most 13, so 4 bits always reach DATA_W-1.
  localparam int BCD_DIGITS = 4;
  localparam int ITER_W     = 4;

  // Segment patterns, active-low: {a, b, c, d, e, f, g}
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Digit enables, active-low, leftmost digit first
  localparam logic [3:0] ANODE_THOU = 4'b0111;
  localparam logic [3:0] ANODE_HUND = 4'b1011;
  localparam logic [3:0] ANODE_TENS = 4'b1101;
  localparam logic [3:0] ANODE_ONES = 4'b1110;

  // Double-dabble correction: every digit >= 5 gets +3. Each add is kept
  // to 4 bits so no carry ever ripples into the neighbouring digit.
  function automatic logic [15:0] bcd_adjust(input logic [15:0] s);
    logic [15:0] r;
    r = s;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (s[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = s[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/lipsi_seg_decode.sv
// Combinational BCD digit to seven-segment decoder (active-low segments).
// Ports: digit (4-bit BCD), blank (force all segments off) -> seg (7-bit,
// bit 6 = a .. bit 0 = g). Codes above 9 decode as 0.
module lipsi_seg_decode
  import lipsi_disp_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_0;
    if (blank) begin
      seg = SEG_BLANK;
    end else begin
      case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_0;
      endcase
    end
  end

endmodule

// File: rtl/lipsi_bcd_display.sv
// Binary-to-BCD converter (sequential shift-add-3) driving a 4-digit
// time-multiplexed common-anode seven-segment display.
// Ports: clk, reset_n (async active-low), value/value_valid (request,
// sampled only in IDLE), busy, bcd {thou,hund,tens,ones}, anode, seg.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
module lipsi_bcd_display
  import lipsi_disp_pkg::*;
#(
  parameter int DATA_W       = 8,   // 1..13 so the result stays <= 9999
  parameter int REFRESH_BITS = 20   // scan counter width, >= 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] value,
  input  logic              value_valid,
  output logic              busy,
  output logic [15:0]       bcd,
  output logic [3:0]        anode,
  output logic [6:0]        seg
);

  state_t                  state;
  logic [DATA_W-1:0]       shreg;
  logic [15:0]             scratch;
  logic [ITER_W-1:0]       iter;
  logic [REFRESH_BITS-1:0] scan_cnt;

  logic [15:0] scratch_adj;
  logic        unused_adj_msb;

  assign scratch_adj = bcd_adjust(scratch);
  // The top scratch bit is shifted out every iteration; with DATA_W <= 13
  // it is always zero, so dropping it loses nothing.
  assign unused_adj_msb = scratch_adj[15];

  // Conversion FSM. bcd only ever takes a fully converted scratch value,
  // in DONE, so the display never sees a partial result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      shreg   <= '0;
      scratch <= '0;
      iter    <= '0;
      bcd     <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (value_valid) begin
            shreg   <= value;
            scratch <= '0;
            iter    <= '0;
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          // Adjust first, then shift {scratch, shreg} left by one.
          scratch <= {scratch_adj[14:0], shreg[DATA_W-1]};
          shreg   <= shreg << 1;
          iter    <= iter + ITER_W'(1);
          if (iter == ITER_W'(DATA_W - 1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          bcd   <= scratch;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Free-running scan counter; wraps naturally at 2^REFRESH_BITS.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scan_cnt <= '0;
    end else begin
      scan_cnt <= scan_cnt + REFRESH_BITS'(1);
    end
  end

  // Leading-zero blanking flags: a digit blanks only when it and every
  // more-significant digit are zero. The ones digit is never blanked.
  logic blank_thou;
  logic blank_hund;
  logic blank_tens;

`ifdef LEADING_ZERO_BLANK_EN
  assign blank_thou = (bcd[15:12] == 4'd0);
  assign blank_hund = (bcd[15:8]  == 8'd0);
  assign blank_tens = (bcd[15:4]  == 12'd0);
`else
  assign blank_thou = 1'b0;
  assign blank_hund = 1'b0;
  assign blank_tens = 1'b0;
`endif

  // Digit mux driven only by registered state (scan counter and bcd).
  logic [1:0] sel;
  logic [3:0] digit;
  logic       blank;

  assign sel = scan_cnt[REFRESH_BITS-1 -: 2];

  always_comb begin
    anode = ANODE_THOU;
    digit = bcd[15:12];
    blank = blank_thou;
    case (sel)
      2'b00: begin
        anode = ANODE_THOU;
        digit = bcd[15:12];
        blank = blank_thou;
      end
      2'b01: begin
        anode = ANODE_HUND;
        digit = bcd[11:8];
        blank = blank_hund;
      end
      2'b10: begin
        anode = ANODE_TENS;
        digit = bcd[7:4];
        blank = blank_tens;
      end
      default: begin
        anode = ANODE_ONES;
        digit = bcd[3:0];
        blank = 1'b0;
      end
    endcase
  end

  lipsi_seg_decode u_seg_decode (
    .digit (digit),
    .blank (blank),
    .seg   (seg)
  );

endmodule

// File: tb/tb_lipsi_bcd_display.sv
// Directed self-checking bench for lipsi_bcd_display: an 8-bit instance
// with a 4-bit scan counter and a 13-bit instance with the default scan.
module tb_lipsi_bcd_display;

  logic        clk = 1'b0;
  logic        reset_n;

  logic [7:0]  value;
  logic        value_valid;
  logic        busy;
  logic [15:0] bcd;
  logic [3:0]  anode;
  logic [6:0]  seg;

  logic [12:0] value13;
  logic        valid13;
  logic        busy13;
  logic [15:0] bcd13;
  logic [3:0]  anode13;
  logic [6:0]  seg13;

  int errors = 0;
  int checks = 0;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] EXP_THOU_ZERO = 7'b1111111;
`else
  localparam logic [6:0] EXP_THOU_ZERO = 7'b0000001;
`endif

  always #5 clk = ~clk;

  lipsi_bcd_display #(.DATA_W(8), .REFRESH_BITS(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .value       (value),
    .value_valid (value_valid),
    .busy        (busy),
    .bcd         (bcd),
    .anode       (anode),
    .seg         (seg)
  );

  lipsi_bcd_display #(.DATA_W(13), .REFRESH_BITS(20)) dut13 (
    .clk         (clk),
    .reset_n     (reset_n),
    .value       (value13),
    .value_valid (valid13),
    .busy        (busy13),
    .bcd         (bcd13),
    .anode       (anode13),
    .seg         (seg13)
  );

  // Counts busy-high negedges of the 8-bit instance until it drops.
  task automatic wait_done8(input string name, output int cycles);
    cycles = 0;
    while (busy !== 1'b0 && cycles < 40) begin
      cycles++;
      @(negedge clk);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s timeout: busy=%b required 0", name, busy);
    end
  endtask

  task automatic wait_done13(input string name, output int cycles);
    cycles = 0;
    while (busy13 !== 1'b0 && cycles < 40) begin
      cycles++;
      @(negedge clk);
    end
    checks++;
    if (busy13 !== 1'b0) begin
      errors++;
      $display("FAIL %s timeout: busy=%b required 0", name, busy13);
    end
  endtask

  task automatic test_reset;
    reset_n     = 1'b0;
    value       = '0;
    value_valid = 1'b0;
    value13     = '0;
    valid13     = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    checks++; if (bcd !== 16'h0000) begin errors++; $display("FAIL reset_bcd: got %h required 0000", bcd); end
    checks++; if (anode !== 4'b0111) begin errors++; $display("FAIL reset_anode: got %b required 0111", anode); end
    checks++; if (seg !== EXP_THOU_ZERO) begin errors++; $display("FAIL reset_seg: got %b required %b", seg, EXP_THOU_ZERO); end
    checks++; if (busy13 !== 1'b0 || bcd13 !== 16'h0000) begin errors++; $display("FAIL reset_dut13: busy=%b bcd=%h required 0/0000", busy13, bcd13); end
    checks++; if (anode13 !== 4'b0111) begin errors++; $display("FAIL reset_anode13: got %b required 0111", anode13); end
    // With a 4-bit counter the anode would have moved if the counter ran.
    repeat (5) @(negedge clk);
    checks++; if (anode !== 4'b0111) begin errors++; $display("FAIL reset_counter_frozen: anode %b required 0111", anode); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_255;
    int cyc;
    value = 8'd255; value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_rise_255: got %b required 1", busy); end
    wait_done8("conv_255", cyc);
    checks++; if (cyc != 9) begin errors++; $display("FAIL busy_len_255: got %0d cycles required 9", cyc); end
    checks++; if (bcd !== 16'h0255) begin errors++; $display("FAIL bcd_255: got %h required 0255", bcd); end
    repeat (5) @(negedge clk);
    checks++; if (bcd !== 16'h0255 || busy !== 1'b0) begin errors++; $display("FAIL hold_255: bcd=%h busy=%b required 0255/0", bcd, busy); end
  endtask

  task automatic test_back_to_back;
    logic [7:0]  vin [3] = '{8'd0, 8'd99, 8'd100};
    logic [15:0] vexp[3] = '{16'h0000, 16'h0099, 16'h0100};
    int cyc;
    value_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      value = vin[i];
      @(negedge clk);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_start_%0d: busy %b required 1", i, busy); end
      wait_done8("b2b", cyc);
      checks++; if (cyc != 9) begin errors++; $display("FAIL b2b_len_%0d: got %0d required 9", i, cyc); end
      checks++; if (bcd !== vexp[i]) begin errors++; $display("FAIL b2b_bcd_%0d: got %h required %h", i, bcd, vexp[i]); end
    end
    value_valid = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_stop: busy %b required 0", busy); end
  endtask

  task automatic test_wide;
    logic [12:0] vin [2] = '{13'd8191, 13'd1000};
    logic [15:0] vexp[2] = '{16'h8191, 16'h1000};
    int cyc;
    valid13 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      value13 = vin[i];
      @(negedge clk);
      wait_done13("wide", cyc);
      checks++; if (cyc != 14) begin errors++; $display("FAIL wide_len_%0d: got %0d required 14", i, cyc); end
      checks++; if (bcd13 !== vexp[i]) begin errors++; $display("FAIL wide_bcd_%0d: got %h required %h", i, bcd13, vexp[i]); end
    end
    valid13 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ignore_while_busy;
    int cyc;
    value = 8'd200; value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
    repeat (2) @(negedge clk);
    value = 8'd17; value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
    wait_done8("ignore_200", cyc);
    checks++; if (bcd !== 16'h0200) begin errors++; $display("FAIL ignore_bcd: got %h required 0200", bcd); end
    repeat (12) @(negedge clk);
    checks++; if (busy !== 1'b0 || bcd !== 16'h0200) begin errors++; $display("FAIL ignore_no_queue: busy=%b bcd=%h required 0/0200", busy, bcd); end
    value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
    wait_done8("ignore_17", cyc);
    checks++; if (bcd !== 16'h0017) begin errors++; $display("FAIL ignore_new_req: got %h required 0017", bcd); end
  endtask

  task automatic test_scan;
    logic [3:0] exp_an[4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    logic [6:0] exp_sg[4];
    logic [3:0] prev;
    bit         found;
    int         cyc;
    exp_sg[0] = EXP_THOU_ZERO;
    exp_sg[1] = 7'b1001111;
    exp_sg[2] = 7'b0000110;
    exp_sg[3] = 7'b0001111;
    value = 8'd137; value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
    wait_done8("scan_137", cyc);
    checks++; if (bcd !== 16'h0137) begin errors++; $display("FAIL scan_bcd: got %h required 0137", bcd); end
    prev  = anode;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      @(negedge clk);
      if (anode === 4'b0111 && prev !== 4'b0111) found = 1'b1;
      else prev = anode;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL scan_sync: no entry into anode 0111 within 20 cycles");
    end else begin
      for (int k = 0; k < 20; k++) begin
        if (k != 0) @(negedge clk);
        checks++;
        if (anode !== exp_an[(k/4)%4] || seg !== exp_sg[(k/4)%4]) begin
          errors++;
          $display("FAIL scan_step_%0d: anode=%b seg=%b required %b/%b", k, anode, seg, exp_an[(k/4)%4], exp_sg[(k/4)%4]);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    int cyc;
    value = 8'd255; value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b required 1", busy); end
    reset_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy: got %b required 0", busy); end
    checks++; if (bcd !== 16'h0000) begin errors++; $display("FAIL mid_reset_bcd: got %h required 0000", bcd); end
    checks++; if (anode !== 4'b0111) begin errors++; $display("FAIL mid_reset_anode: got %b required 0111", anode); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_after_release: busy %b required 0", busy); end
    value = 8'd42; value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
    wait_done8("mid_42", cyc);
    checks++; if (bcd !== 16'h0042) begin errors++; $display("FAIL mid_bcd_42: got %h required 0042", bcd); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_255();
    test_back_to_back();
    test_wide();
    test_ignore_while_busy();
    test_scan();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
